mc_control_unit: RTL and testbench

Multicycle RV32I control FSM with a ready-stalled memory handshake, full base-ISA decode and a bus-timeout/illegal-instruction trap path. Sits between the IR/comparator and the datapath muxes, ALU and memory port. Each instruction takes FETCH plus EXEC, plus MEM for loads and stores; memory phases stretch until `mem_ready`.

---
 rtl/mc_control_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control FSM: FETCH -> EXEC (-> MEM) with mem_ready-stalled memory phases.
// Optional macro CU_TRAP_EN adds illegal-instruction and bus-timeout trapping.
module mc_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] ir,
    input  logic        AltB,
    input  logic        AltuB,
    input  logic        AeqB,
    input  logic        mem_ready,
    output logic [1:0]  pcsel,
    output logic        irsel,
    output logic [1:0]  regsel,
    output logic        regen,
    output logic        alusel0,
    output logic        alusel1,
    output logic [9:0]  op,
    output logic        re,
    output logic        we,
    output logic        addrsel,
    output logic        tmpen,
    output logic [2:0]  size,
    output logic        trap,
    output logic        bus_err
);
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [1:0] PcInc  = 2'd1;
    localparam logic [1:0] PcAlu  = 2'd2;
    localparam logic [1:0] RegMem = 2'd1;
    localparam logic [1:0] RegPc4 = 2'd2;
    localparam logic [1:0] RegImm = 2'd3;

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StTrap} state_e;

`ifdef CU_TRAP_EN
    localparam state_e IllegalNext = StTrap;
`else
    localparam state_e IllegalNext = StFetch;
`endif

    state_e state_q, state_d;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    logic unused_ir;
    assign unused_ir = ^{ir[24:15], ir[11:7]};

    logic is_load, is_store, is_branch, is_jalr, is_jal, is_opimm, is_op, is_lui, is_auipc;
    assign is_load   = (opcode == OpcLoad);
    assign is_store  = (opcode == OpcStore);
    assign is_branch = (opcode == OpcBranch);
    assign is_jalr   = (opcode == OpcJalr);
    assign is_jal    = (opcode == OpcJal);
    assign is_opimm  = (opcode == OpcOpImm);
    assign is_op     = (opcode == OpcOp);
    assign is_lui    = (opcode == OpcLui);
    assign is_auipc  = (opcode == OpcAuipc);

    logic f7_zero, f7_alt, illegal, taken;
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    always_comb begin
        illegal = 1'b0;
        if (is_load) begin
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end else if (is_store) begin
            illegal = (funct3 > 3'b010);
        end else if (is_branch) begin
            illegal = (funct3[2:1] == 2'b01);
        end else if (is_jalr) begin
            illegal = (funct3 != 3'b000);
        end else if (is_op) begin
            illegal = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
        end else if (is_opimm) begin
            illegal = ((funct3 == 3'b001) && !f7_zero) ||
                      ((funct3 == 3'b101) && !(f7_zero || f7_alt));
        end else if (!(is_jal || is_lui || is_auipc)) begin
            illegal = 1'b1;
        end
    end

    // funct3[0] inverts the base condition (BNE/BGE/BGEU).
    always_comb begin
        taken = 1'b0;
        case (funct3[2:1])
            2'b00:   taken = AeqB;
            2'b10:   taken = AltB;
            2'b11:   taken = AltuB;
            default: taken = 1'b0;
        endcase
        taken = taken ^ funct3[0];
    end

`ifdef CU_TRAP_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             stalled, timeout;

    assign stalled   = (state_q == StFetch || state_q == StMem) && !mem_ready;
    assign timeout   = stalled && (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign cnt_d     = (stalled && !timeout) ? cnt_q + 1'b1 : '0;
    assign bus_err_d = (state_q == StTrap) ? bus_err_q : timeout;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = MEM_TIMEOUT ^ CNT_W;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
`ifdef CU_TRAP_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef CU_TRAP_EN
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (mem_ready) state_d = StExec;
`ifdef CU_TRAP_EN
                if (timeout) state_d = StTrap;
`endif
            end
            StExec: begin
                if (illegal)                  state_d = IllegalNext;
                else if (is_load || is_store) state_d = StMem;
                else                          state_d = StFetch;
            end
            StMem: begin
                if (mem_ready) state_d = StFetch;
`ifdef CU_TRAP_EN
                if (timeout) state_d = StTrap;
`endif
            end
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pcsel   = '0;
        irsel   = 1'b0;
        regsel  = '0;
        regen   = 1'b0;
        alusel0 = 1'b0;
        alusel1 = 1'b0;
        op      = '0;
        re      = 1'b0;
        we      = 1'b0;
        addrsel = 1'b0;
        tmpen   = 1'b0;
        size    = '0;
        trap    = 1'b0;
        bus_err = 1'b0;
        case (state_q)
            StFetch: begin
                re    = 1'b1;
                irsel = mem_ready;
            end
            StExec: begin
                if (illegal) begin
`ifndef CU_TRAP_EN
                    pcsel = PcInc;
`endif
                end else begin
                    unique case (1'b1)
                        is_op: begin
                            op    = {funct3, funct7};
                            regen = 1'b1;
                            pcsel = PcInc;
                        end
                        is_opimm: begin
                            alusel1 = 1'b1;
                            op      = {funct3, (funct3 == 3'b101) ? funct7 : 7'b0};
                            regen   = 1'b1;
                            pcsel   = PcInc;
                        end
                        is_lui: begin
                            regsel = RegImm;
                            regen  = 1'b1;
                            pcsel  = PcInc;
                        end
                        is_auipc: begin
                            alusel0 = 1'b1;
                            alusel1 = 1'b1;
                            regen   = 1'b1;
                            pcsel   = PcInc;
                        end
                        is_jal: begin
                            alusel0 = 1'b1;
                            alusel1 = 1'b1;
                            regsel  = RegPc4;
                            regen   = 1'b1;
                            pcsel   = PcAlu;
                        end
                        is_jalr: begin
                            alusel1 = 1'b1;
                            regsel  = RegPc4;
                            regen   = 1'b1;
                            pcsel   = PcAlu;
                        end
                        is_branch: begin
                            alusel0 = 1'b1;
                            alusel1 = 1'b1;
                            pcsel   = taken ? PcAlu : PcInc;
                        end
                        is_load, is_store: begin
                            alusel1 = 1'b1;
                            tmpen   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StMem: begin
                addrsel = 1'b1;
                size    = funct3;
                re      = is_load;
                we      = is_store;
                if (mem_ready) begin
                    pcsel = PcInc;
                    if (is_load) begin
                        regsel = RegMem;
                        regen  = 1'b1;
                    end
                end
            end
`ifdef CU_TRAP_EN
            StTrap: begin
                trap    = !bus_err_q;
                bus_err = bus_err_q;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed scenarios plus random instruction streams checked
// against a behavioural model of the per-phase control outputs.
module tb_mc_control_unit;
    localparam int unsigned TO = 4;
    localparam int NRand = 150;

`ifdef CU_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63, JALR = 7'h67;
    localparam logic [6:0] JAL = 7'h6F, OPIMM = 7'h13, OP = 7'h33, LUI = 7'h37;
    localparam logic [6:0] AUIPC = 7'h17;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] ir = '0;
    logic        AltB = 1'b0, AltuB = 1'b0, AeqB = 1'b0, mem_ready = 1'b0;
    logic [1:0]  pcsel, regsel;
    logic        irsel, regen, alusel0, alusel1, re, we, addrsel, tmpen, trap, bus_err;
    logic [9:0]  op;
    logic [2:0]  size;

    mc_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clock(clock), .resetn(resetn), .ir(ir), .AltB(AltB), .AltuB(AltuB), .AeqB(AeqB),
        .mem_ready(mem_ready), .pcsel(pcsel), .irsel(irsel), .regsel(regsel), .regen(regen),
        .alusel0(alusel0), .alusel1(alusel1), .op(op), .re(re), .we(we), .addrsel(addrsel),
        .tmpen(tmpen), .size(size), .trap(trap), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    typedef struct packed {
        logic [1:0] pcsel;
        logic       irsel;
        logic [1:0] regsel;
        logic       regen;
        logic       alusel0;
        logic       alusel1;
        logic [9:0] op;
        logic       re;
        logic       we;
        logic       addrsel;
        logic       tmpen;
        logic [2:0] size;
        logic       trap;
        logic       bus_err;
    } ctl_t;

    ctl_t got, exp;

    function automatic ctl_t observe();
        ctl_t c;
        c.pcsel = pcsel;     c.irsel = irsel;     c.regsel = regsel;   c.regen = regen;
        c.alusel0 = alusel0; c.alusel1 = alusel1; c.op = op;           c.re = re;
        c.we = we;           c.addrsel = addrsel; c.tmpen = tmpen;     c.size = size;
        c.trap = trap;       c.bus_err = bus_err;
        return c;
    endfunction

    function automatic bit legal(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            LOAD:   return !(f3 inside {3'd3, 3'd6, 3'd7});
            STORE:  return f3 <= 3'd2;
            BRANCH: return !(f3 inside {3'd2, 3'd3});
            JALR:   return f3 == 3'd0;
            OP:     return f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
            OPIMM: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return f7 inside {7'h00, 7'h20};
                return 1'b1;
            end
            JAL, LUI, AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t exp_fetch(input logic rdy);
        ctl_t c = '0;
        c.re = 1'b1;
        c.irsel = rdy;
        return c;
    endfunction

    function automatic ctl_t exp_exec(input logic [31:0] i, input logic lt, ltu, eq);
        ctl_t c = '0;
        logic [2:0] f3;
        bit tk;
        f3 = i[14:12];
        if (!legal(i)) begin
            if (!TrapEn) c.pcsel = 2'd1;
            return c;
        end
        case (i[6:0])
            OP:    begin c.op = {f3, i[31:25]}; c.regen = 1; c.pcsel = 2'd1; end
            OPIMM: begin
                c.alusel1 = 1;
                c.op = {f3, (f3 == 3'd5) ? i[31:25] : 7'd0};
                c.regen = 1; c.pcsel = 2'd1;
            end
            LUI:   begin c.regsel = 2'd3; c.regen = 1; c.pcsel = 2'd1; end
            AUIPC: begin c.alusel0 = 1; c.alusel1 = 1; c.regen = 1; c.pcsel = 2'd1; end
            JAL:   begin
                c.alusel0 = 1; c.alusel1 = 1; c.regsel = 2'd2; c.regen = 1; c.pcsel = 2'd2;
            end
            JALR:  begin c.alusel1 = 1; c.regsel = 2'd2; c.regen = 1; c.pcsel = 2'd2; end
            BRANCH: begin
                case (f3)
                    3'd0: tk = eq;
                    3'd1: tk = !eq;
                    3'd4: tk = lt;
                    3'd5: tk = !lt;
                    3'd6: tk = ltu;
                    default: tk = !ltu;
                endcase
                c.alusel0 = 1; c.alusel1 = 1; c.pcsel = tk ? 2'd2 : 2'd1;
            end
            default: begin c.alusel1 = 1; c.tmpen = 1; end
        endcase
        return c;
    endfunction

    function automatic ctl_t exp_mem(input logic [31:0] i, input logic rdy);
        ctl_t c = '0;
        c.addrsel = 1; c.size = i[14:12];
        c.re = (i[6:0] == LOAD);
        c.we = (i[6:0] == STORE);
        if (rdy) begin
            c.pcsel = 2'd1;
            if (i[6:0] == LOAD) begin c.regsel = 2'd1; c.regen = 1; end
        end
        return c;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom();
        case ($urandom_range(0, 10))
            0: i[6:0] = LOAD;   1: i[6:0] = STORE; 2: i[6:0] = BRANCH; 3: i[6:0] = JALR;
            4: i[6:0] = JAL;    5: i[6:0] = OPIMM; 6: i[6:0] = OP;     7: i[6:0] = LUI;
            8: i[6:0] = AUIPC;  9: i[6:0] = 7'h7F; default: i[6:0] = 7'h0B;
        endcase
        if (i[6:0] inside {OP, OPIMM}) begin
            case ($urandom_range(0, 3))
                0, 1:    i[31:25] = 7'h00;
                2:       i[31:25] = 7'h20;
                default: ;
            endcase
        end
        return i;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT in its first FETCH cycle, just after the clock edge.
    task automatic do_reset();
        @(posedge clock);
        #3 resetn = 1'b0;
        mem_ready = 1'b0;
        #2 resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        ir = 32'h002081B3;
        #2;
        got = observe(); n_total++;
        if (got !== '0) $display("FAIL reset_async: got %h want %h", got, ctl_t'('0));
        else n_pass++;
        #5;
        got = observe(); n_total++;
        if (got !== '0) $display("FAIL reset_clocked: got %h want %h", got, ctl_t'('0));
        else n_pass++;
        #1 resetn = 1'b1;
        #1;
        got = observe(); n_total++;
        if (got !== '0) $display("FAIL idle: got %h want %h", got, ctl_t'('0));
        else n_pass++;
        next_cycle();
        mem_ready = 1'b0;
        #3;
        got = observe(); exp = exp_fetch(1'b0); n_total++;
        if (got !== exp) $display("FAIL first_fetch: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_alu_add();
        do_reset();
        ir = 32'h002081B3;
        mem_ready = 1'b1;
        #3;
        got = observe(); exp = '0; exp.re = 1; exp.irsel = 1; n_total++;
        if (got !== exp) $display("FAIL add_fetch: got %h want %h", got, exp);
        else n_pass++;
        next_cycle();
        mem_ready = 1'b0;
        #3;
        got = observe(); exp = '0; exp.pcsel = 2'd1; exp.regen = 1; n_total++;
        if (got !== exp) $display("FAIL add_exec: got %h want %h", got, exp);
        else n_pass++;
        next_cycle();
        #3;
        got = observe(); exp = '0; exp.re = 1; n_total++;
        if (got !== exp) $display("FAIL add_refetch: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_load_stall();
        do_reset();
        ir = 32'h0040A183;
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        #3;
        got = observe(); exp = '0; exp.alusel1 = 1; exp.tmpen = 1; n_total++;
        if (got !== exp) $display("FAIL lw_exec: got %h want %h", got, exp);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            mem_ready = (k == 3);
            #3;
            exp = '0; exp.re = 1; exp.addrsel = 1; exp.size = 3'b010;
            if (k == 3) begin exp.regen = 1; exp.regsel = 2'd1; exp.pcsel = 2'd1; end
            got = observe(); n_total++;
            if (got !== exp) $display("FAIL lw_mem%0d: got %h want %h", k, got, exp);
            else n_pass++;
        end
        next_cycle();
        mem_ready = 1'b0;
        #3;
        got = observe(); exp = '0; exp.re = 1; n_total++;
        if (got !== exp) $display("FAIL lw_refetch: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            do_reset();
            ir = 32'h00208463;
            AeqB = t[0];
            AltB = 1'($urandom_range(0, 1));
            AltuB = 1'($urandom_range(0, 1));
            mem_ready = 1'b1;
            next_cycle();
            mem_ready = 1'b0;
            #3;
            exp = '0; exp.alusel0 = 1; exp.alusel1 = 1; exp.pcsel = t[0] ? 2'd2 : 2'd1;
            got = observe(); n_total++;
            if (got !== exp) $display("FAIL beq_eq%0d: got %h want %h", t, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        ir = 32'h0020A423;
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();
        #2;
        got = observe(); exp = '0; exp.we = 1; exp.addrsel = 1; exp.size = 3'b010; n_total++;
        if (got !== exp) $display("FAIL sw_mem: got %h want %h", got, exp);
        else n_pass++;
        #1 resetn = 1'b0;
        #1;
        n_total++;
        if (we !== 1'b0) $display("FAIL sw_async_we: got %b want 0", we);
        else n_pass++;
        got = observe(); n_total++;
        if (got !== '0) $display("FAIL sw_async_all: got %h want %h", got, ctl_t'('0));
        else n_pass++;
        #2 resetn = 1'b1;
        #1;
        got = observe(); n_total++;
        if (got !== '0) $display("FAIL sw_idle: got %h want %h", got, ctl_t'('0));
        else n_pass++;
        next_cycle();
        #3;
        got = observe(); exp = exp_fetch(1'b0); n_total++;
        if (got !== exp) $display("FAIL sw_refetch: got %h want %h", got, exp);
        else n_pass++;
    endtask

`ifdef CU_TRAP_EN
    task automatic test_trap_illegal();
        do_reset();
        ir = 32'h0000707F;
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        #3;
        got = observe(); n_total++;
        if (got !== '0) $display("FAIL ill_exec: got %h want %h", got, ctl_t'('0));
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            mem_ready = 1'($urandom_range(0, 1));
            #3;
            got = observe(); exp = '0; exp.trap = 1; n_total++;
            if (got !== exp) $display("FAIL ill_trap%0d: got %h want %h", k, got, exp);
            else n_pass++;
        end
        mem_ready = 1'b0;
        resetn = 1'b0;
        #1;
        got = observe(); n_total++;
        if (got !== '0) $display("FAIL ill_reset: got %h want %h", got, ctl_t'('0));
        else n_pass++;
        #2 resetn = 1'b1;
        next_cycle();
        #3;
        got = observe(); exp = exp_fetch(1'b0); n_total++;
        if (got !== exp) $display("FAIL ill_refetch: got %h want %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k <= int'(TO); k++) begin
            mem_ready = 1'b0;
            #3;
            got = observe(); exp = exp_fetch(1'b0); n_total++;
            if (got !== exp) $display("FAIL to_fetch%0d: got %h want %h", k, got, exp);
            else n_pass++;
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #3;
            got = observe(); exp = '0; exp.bus_err = 1; n_total++;
            if (got !== exp) $display("FAIL to_buserr%0d: got %h want %h", k, got, exp);
            else n_pass++;
            next_cycle();
        end
        do_reset();
        ir = 32'h002081B3;
        for (int k = 0; k <= int'(TO); k++) begin
            mem_ready = (k == int'(TO));
            next_cycle();
        end
        mem_ready = 1'b0;
        #3;
        got = observe(); exp = exp_exec(32'h002081B3, 1'b0, 1'b0, 1'b0); n_total++;
        if (got !== exp) $display("FAIL to_ready_wins: got %h want %h", got, exp);
        else n_pass++;
        do_reset();
        ir = 32'h0020A423;
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        next_cycle();
        for (int k = 0; k <= int'(TO); k++) next_cycle();
        #3;
        got = observe(); exp = '0; exp.bus_err = 1; n_total++;
        if (got !== exp) $display("FAIL to_mem_buserr: got %h want %h", got, exp);
        else n_pass++;
    endtask
`else
    task automatic test_illegal_nop();
        logic [31:0] ills [3] = '{32'h0000707F, 32'h0000B003, 32'h40209033};
        for (int n = 0; n < 3; n++) begin
            do_reset();
            ir = ills[n];
            mem_ready = 1'b1;
            next_cycle();
            mem_ready = 1'b0;
            #3;
            got = observe(); exp = '0; exp.pcsel = 2'd1; n_total++;
            if (got !== exp) $display("FAIL nop_exec%0d: got %h want %h", n, got, exp);
            else n_pass++;
            next_cycle();
            #3;
            got = observe(); exp = exp_fetch(1'b0); n_total++;
            if (got !== exp) $display("FAIL nop_refetch%0d: got %h want %h", n, got, exp);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] instr;
        int fs, ms;
        logic lt, ltu, eq;
        do_reset();
        for (int n = 0; n < NRand; n++) begin
            instr = rand_instr();
            fs = $urandom_range(0, TO);
            ms = $urandom_range(0, TO);
            lt = 1'($urandom_range(0, 1));
            ltu = 1'($urandom_range(0, 1));
            eq = 1'($urandom_range(0, 1));
            ir = instr; AltB = lt; AltuB = ltu; AeqB = eq;
            for (int k = 0; k <= fs; k++) begin
                mem_ready = (k == fs);
                #3;
                got = observe(); exp = exp_fetch(k == fs); n_total++;
                if (got !== exp) $display("FAIL rnd_fetch %h: got %h want %h", instr, got, exp);
                else n_pass++;
                next_cycle();
            end
            mem_ready = 1'($urandom_range(0, 1));
            #3;
            got = observe(); exp = exp_exec(instr, lt, ltu, eq); n_total++;
            if (got !== exp) $display("FAIL rnd_exec %h: got %h want %h", instr, got, exp);
            else n_pass++;
            next_cycle();
            if (!legal(instr)) begin
`ifdef CU_TRAP_EN
                #3;
                got = observe(); exp = '0; exp.trap = 1; n_total++;
                if (got !== exp) $display("FAIL rnd_trap %h: got %h want %h", instr, got, exp);
                else n_pass++;
                do_reset();
`endif
                continue;
            end
            if (instr[6:0] inside {LOAD, STORE}) begin
                for (int k = 0; k <= ms; k++) begin
                    mem_ready = (k == ms);
                    #3;
                    got = observe(); exp = exp_mem(instr, k == ms); n_total++;
                    if (got !== exp) $display("FAIL rnd_mem %h: got %h want %h", instr, got, exp);
                    else n_pass++;
                    next_cycle();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_load_stall();
        test_branch();
        test_reset_mid_store();
`ifdef CU_TRAP_EN
        test_trap_illegal();
        test_timeout();
`else
        test_illegal_nop();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1);
    end

endmodule
